// File: rtl/gaussian_window_ctrl_if.sv
// Pixel-in / window-out signal bundle between the host stream and the gaussian window controller.
interface gaussian_window_ctrl_if;
   logic [7:0]  pixel_in;
   logic        pixel_in_valid;
   logic        proc_enable;
   logic [71:0] window_data;
   logic        window_valid;
   logic        line_done_intr;
   logic [2:0]  lines_stored;
   logic        busy;
   logic        overflow;

   modport master (
      output pixel_in, pixel_in_valid, proc_enable,
      input  window_data, window_valid, line_done_intr, lines_stored, busy, overflow
   );

   modport slave (
      input  pixel_in, pixel_in_valid, proc_enable,
      output window_data, window_valid, line_done_intr, lines_stored, busy, overflow
   );
endinterface

// File: rtl/gaussian_window_ctrl.sv
// Four rotating line buffers feeding 3x3 windows to the gaussian filter;
// one window per cycle once three complete lines are held.
module gaussian_window_ctrl #(
   parameter int IMG_WIDTH = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   gaussian_window_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(IMG_WIDTH);

   typedef enum logic {IDLE, READ} state_t;

   state_t           state_reg, state_next;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [1:0]       wr_lb_reg;
   logic [1:0]       rd_lb_reg, rd_lb_next;
   logic [2:0]       lines_stored_reg, lines_stored_next;
   logic             overflow_reg;
   logic [71:0]      window_reg, window_next;
   logic             window_valid_reg;
   logic             intr_reg;
   logic             wr_accept, line_complete, line_retire, rd_active;

   logic [7:0] line_mem [0:3][0:IMG_WIDTH-1];

   assign wr_accept     = bus.pixel_in_valid && (lines_stored_reg != 3'd4);
   assign line_complete = wr_accept && (wr_ptr_reg == PTR_W'(IMG_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst && wr_accept)
         line_mem[wr_lb_reg][wr_ptr_reg] <= bus.pixel_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         wr_lb_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (bus.pixel_in_valid) begin
         if (wr_accept) begin
            if (line_complete) begin
               wr_ptr_reg <= '0;
               wr_lb_reg  <= wr_lb_reg + 2'd1;
            end else begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
         end else begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Read sequencer: one column step per cycle, retiring the top line at the end.
   always_comb begin
      state_next  = state_reg;
      rd_ptr_next = rd_ptr_reg;
      rd_lb_next  = rd_lb_reg;
      line_retire = 1'b0;
      rd_active   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (lines_stored_reg >= 3'd3 && bus.proc_enable) begin
               state_next  = READ;
               rd_ptr_next = '0;
            end
         end
         READ: begin
            rd_active   = 1'b1;
            rd_ptr_next = rd_ptr_reg + 1'b1;
            if (rd_ptr_reg == PTR_W'(IMG_WIDTH - 3)) begin
               state_next  = IDLE;
               line_retire = 1'b1;
               rd_lb_next  = rd_lb_reg + 2'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      lines_stored_next = lines_stored_reg + {2'b00, line_complete} - {2'b00, line_retire};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         rd_ptr_reg       <= '0;
         rd_lb_reg        <= '0;
         lines_stored_reg <= '0;
      end else begin
         state_reg        <= state_next;
         rd_ptr_reg       <= rd_ptr_next;
         rd_lb_reg        <= rd_lb_next;
         lines_stored_reg <= lines_stored_next;
      end
   end

   // Tap gi sits at row gi/3 (buffer rd_lb+row, wrapping) and column rd_ptr+gi%3.
   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_tap
         localparam int ROW = gi / 3;
         localparam int COL = gi % 3;
         assign window_next[8*gi +: 8] = line_mem[rd_lb_reg + 2'(ROW)][rd_ptr_reg + PTR_W'(COL)];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         window_reg       <= '0;
         window_valid_reg <= 1'b0;
         intr_reg         <= 1'b0;
      end else begin
         window_valid_reg <= rd_active;
         intr_reg         <= line_retire;
         if (rd_active)
            window_reg <= window_next;
      end
   end

   assign bus.window_data    = window_reg;
   assign bus.window_valid   = window_valid_reg;
   assign bus.line_done_intr = intr_reg;
   assign bus.lines_stored   = lines_stored_reg;
   assign bus.busy           = (state_reg == READ);
   assign bus.overflow       = overflow_reg;
endmodule
